// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, requester ids and read-tag type for the dmem arbiter
package dmem_pkg;
    localparam int DMEM_AW = 12;
    localparam int DMEM_DW = 32;
    localparam logic REQ_PROC = 1'b0;
    localparam logic REQ_HOST = 1'b1;
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of read tags aligned with the syncram latency
module rd_tag_pipe import dmem_pkg::*; #(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_head
);
    tag_t [RD_LAT-1:0] pipe_d, pipe_q;
    // shift one stage per cycle, new tag enters at stage 0
    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
    // tag register, cleared by reset so in-flight reads are dropped
    always_ff @(posedge clock) begin
        pipe_q <= reset ? '0 : pipe_d;
    end
    assign tag_head = pipe_q[RD_LAT-1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded host lock in front of the dmem syncram
module dmem_arbiter import dmem_pkg::*; #(
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               p_req,
    input  logic               p_wren,
    input  logic [DMEM_AW-1:0] p_addr,
    input  logic [DMEM_DW-1:0] p_wdata,
    input  logic               h_req,
    input  logic               h_wren,
    input  logic [DMEM_AW-1:0] h_addr,
    input  logic [DMEM_DW-1:0] h_wdata,
    input  logic               h_lock,
    output logic               p_gnt,
    output logic               h_gnt,
    output logic               p_rvalid,
    output logic [DMEM_DW-1:0] p_rdata,
    output logic               h_rvalid,
    output logic [DMEM_DW-1:0] h_rdata,
    output logic [DMEM_AW-1:0] mem_address,
    output logic [DMEM_DW-1:0] mem_data,
    output logic               mem_wren,
    input  logic [DMEM_DW-1:0] mem_q
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic          last_gnt_d, last_gnt_q;
    logic          h_prev_d, h_prev_q;
    logic [CW-1:0] lock_cnt_d, lock_cnt_q;
    logic          lock_room, lock_hold;
    tag_t          tag_in, tag_head;
    // winner selection and memory port mux; nothing is granted while in reset
    always_comb begin
        lock_room   = lock_cnt_q < CW'(LOCK_MAX);
        lock_hold   = h_lock && h_prev_q && lock_room;
        h_gnt       = !reset && h_req && (!p_req || lock_hold || last_gnt_q == REQ_PROC);
        p_gnt       = !reset && p_req && !h_gnt;
        mem_wren    = p_gnt ? p_wren : h_gnt && h_wren;
        mem_address = p_gnt ? p_addr : h_gnt ? h_addr : '0;
        mem_data    = p_gnt ? p_wdata : h_gnt ? h_wdata : '0;
        tag_in      = '{valid: (p_gnt && !p_wren) || (h_gnt && !h_wren), id: h_gnt};
    end
    // next state: a host grant that does not continue a lock restarts the count
    always_comb begin
        last_gnt_d = p_gnt ? REQ_PROC : h_gnt ? REQ_HOST : last_gnt_q;
        h_prev_d   = h_gnt;
        lock_cnt_d = (!h_lock || p_gnt || (h_gnt && !h_prev_q)) ? '0 :
                     (h_gnt && lock_room) ? lock_cnt_q + CW'(1) : lock_cnt_q;
    end
    // arbitration state; host counts as last granted so the processor wins first
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_q <= REQ_HOST;
            h_prev_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            h_prev_q   <= h_prev_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_head(tag_head)
    );
    // route read data back to the requester whose tag reaches the head
    always_comb begin
        p_rvalid = !reset && tag_head.valid && tag_head.id == REQ_PROC;
        h_rvalid = !reset && tag_head.valid && tag_head.id == REQ_HOST;
        p_rdata  = p_rvalid ? mem_q : '0;
        h_rdata  = h_rvalid ? mem_q : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic on RD_LAT=1 and RD_LAT=2 arbiters against a reference model
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 4;

    typedef struct { int g; logic lk; } hist_t;
    typedef struct { int gc; logic id; logic [31:0] data; } rd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p_req = 1'b0, h_req = 1'b0, p_wren = 1'b0, h_wren = 1'b0, h_lock = 1'b0;
    logic [11:0] p_addr = '0, h_addr = '0;
    logic [31:0] p_wdata = '0, h_wdata = '0;
    logic        p_gnt [2], h_gnt [2], p_rvalid [2], h_rvalid [2], mem_wren [2];
    logic [31:0] p_rdata [2], h_rdata [2], mem_data [2], mem_q [2];
    logic [11:0] mem_address [2];
    logic [31:0] smem [2][4096];
    logic [31:0] qp [2][2];

    hist_t       hist [$];
    rd_t         rds [$];
    logic [31:0] mem_m [int];
    logic        last_h = 1'b1;
    int          cyc = 0, lw = -1, nchk = 0, nerr = 0;

    dmem_arbiter #(.RD_LAT(1), .LOCK_MAX(LOCK_MAX)) u_lat1 (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .h_req(h_req), .h_wren(h_wren), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .p_gnt(p_gnt[0]), .h_gnt(h_gnt[0]),
        .p_rvalid(p_rvalid[0]), .p_rdata(p_rdata[0]), .h_rvalid(h_rvalid[0]), .h_rdata(h_rdata[0]),
        .mem_address(mem_address[0]), .mem_data(mem_data[0]), .mem_wren(mem_wren[0]), .mem_q(mem_q[0])
    );

    dmem_arbiter #(.RD_LAT(2), .LOCK_MAX(LOCK_MAX)) u_lat2 (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .h_req(h_req), .h_wren(h_wren), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .p_gnt(p_gnt[1]), .h_gnt(h_gnt[1]),
        .p_rvalid(p_rvalid[1]), .p_rdata(p_rdata[1]), .h_rvalid(h_rvalid[1]), .h_rdata(h_rdata[1]),
        .mem_address(mem_address[1]), .mem_data(mem_data[1]), .mem_wren(mem_wren[1]), .mem_q(mem_q[1])
    );

    assign mem_q[0] = qp[0][0];
    assign mem_q[1] = qp[1][1];

    always #5 clock = ~clock;

    // behavioural syncrams: registered address, write-first for the next access
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wren[d]) smem[d][mem_address[d]] <= mem_data[d];
            qp[d][0] <= smem[d][mem_address[d]];
            qp[d][1] <= qp[d][0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] pool();
        int a = $urandom_range(0, 15);
        return a == 15 ? 12'hFFF : 12'(a);
    endfunction

    // expected winner: -1 none, 0 processor, 1 host
    function automatic int pick();
        int k = 0;
        int n = hist.size();
        if (reset || (!p_req && !h_req)) return -1;
        if (p_req != h_req) return p_req ? 0 : 1;
        for (int i = n - 1; i > 0 && hist[i].g == 1 && hist[i].lk && hist[i-1].g == 1; i--) k++;
        if (h_lock && n > 0 && hist[n-1].g == 1 && k < LOCK_MAX) return 1;
        return last_h ? 0 : 1;
    endfunction

    // check one cycle on both DUTs, advance the model, move to the next falling edge
    task automatic step(input int want = -2);
        int w, a;
        logic wr;
        logic [31:0] wd, ed;
        logic [1:0] ev;
        #1;
        w = pick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("gnt%0d", d), {p_gnt[d], h_gnt[d]}, {w == 0, w == 1});
            if (want != -2) chk($sformatf("pat%0d", d), {p_gnt[d], h_gnt[d]}, want == 0 ? 2'b10 : 2'b01);
            chk($sformatf("wren%0d", d), mem_wren[d], w == 0 ? p_wren : w == 1 ? h_wren : 1'b0);
            chk($sformatf("addr%0d", d), mem_address[d], w == 0 ? p_addr : w == 1 ? h_addr : 12'h0);
            chk($sformatf("wdata%0d", d), mem_data[d], w == 0 ? p_wdata : w == 1 ? h_wdata : 32'h0);
            ev = 2'b00;
            ed = '0;
            if (!reset)
                foreach (rds[i])
                    if (rds[i].gc + d + 1 == cyc) begin
                        ev = rds[i].id ? 2'b01 : 2'b10;
                        ed = rds[i].data;
                    end
            chk($sformatf("rvalid%0d", d), {p_rvalid[d], h_rvalid[d]}, ev);
            chk($sformatf("rdata%0d", d), {p_rdata[d], h_rdata[d]}, {ev[1] ? ed : 32'h0, ev[0] ? ed : 32'h0});
        end
        if (reset) begin
            hist.delete();
            rds.delete();
            last_h = 1'b1;
        end else begin
            hist.push_back('{w, h_lock});
            if (hist.size() > 32) void'(hist.pop_front());
            if (w >= 0) begin
                last_h = w == 1;
                wr = w == 1 ? h_wren : p_wren;
                a = int'(w == 1 ? h_addr : p_addr);
                wd = w == 1 ? h_wdata : p_wdata;
                if (wr) mem_m[a] = wd;
                else rds.push_back('{cyc, w == 1, mem_m.exists(a) ? mem_m[a] : 32'h0});
            end
        end
        while (rds.size() > 0 && rds[0].gc + 2 < cyc) void'(rds.pop_front());
        lw = w;
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle();
        p_req = 1'b0;
        h_req = 1'b0;
        h_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        @(negedge clock);
        step();
        do_reset();
        for (int i = 0; i < 5; i++) step();

        // host preload of the address pool
        for (int i = 0; i < 16; i++) begin
            h_req = 1'b1;
            h_wren = 1'b1;
            h_addr = i == 15 ? 12'hFFF : 12'(i);
            h_wdata = $urandom;
            step(1);
        end
        idle();
        step();

        // processor write then read of 0x010
        p_req = 1'b1;
        p_wren = 1'b1;
        p_addr = 12'h010;
        p_wdata = 32'hDEADBEEF;
        step(0);
        p_wren = 1'b0;
        step(0);
        idle();
        #1 chk("beef_lat1", {h_rvalid[0], p_rvalid[0], p_rdata[0]}, {2'b01, 32'hDEADBEEF});
        step();
        #1 chk("beef_lat2", {h_rvalid[1], p_rvalid[1], p_rdata[1]}, {2'b01, 32'hDEADBEEF});
        step();
        step();

        // contention without lock alternates starting with the processor
        do_reset();
        p_req = 1'b1;
        p_wren = 1'b0;
        p_addr = 12'h001;
        h_req = 1'b1;
        h_wren = 1'b0;
        h_addr = 12'h002;
        for (int i = 0; i < 4; i++) step(i % 2);
        idle();
        step();
        step();
        step();

        // bounded host lock: H,H,H,H,H,P,H,H
        h_req = 1'b1;
        h_lock = 1'b1;
        h_wren = 1'b0;
        h_addr = 12'h003;
        step(1);
        p_req = 1'b1;
        p_wren = 1'b0;
        p_addr = 12'h004;
        for (int i = 0; i < 7; i++) step(i == 4 ? 0 : 1);
        idle();
        step();
        step();
        step();

        // reset while a host read is in flight
        h_req = 1'b1;
        h_wren = 1'b0;
        h_addr = 12'h005;
        step(1);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // random traffic with requesters holding until granted
        for (int n = 0; n < 2000; n++) begin
            if (!p_req || lw == 0) begin
                p_req = $urandom_range(0, 2) != 0;
                p_wren = 1'($urandom_range(0, 1));
                p_addr = pool();
                p_wdata = $urandom;
            end
            if (!h_req || lw == 1) begin
                h_req = $urandom_range(0, 2) != 0;
                h_wren = 1'($urandom_range(0, 1));
                h_addr = pool();
                h_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) h_lock = !h_lock;
            step();
        end
        idle();
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
